proc_io_dispatch: RTL and testbench

PROC_IO_DISPATCH -- requirements
Module: proc_io_dispatch

---
 rtl/proc_io_dispatch.sv | 165 ++++++++++++++++
 tb/tb_proc_io_dispatch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_io_dispatch.sv
// Processor I/O dispatcher: 4-entry in-order request FIFO routed to ETH/PPU/ACC ports.
// Optional saturating drop counter enabled by IO_DISPATCH_DROP_CNT_EN.
module proc_io_dispatch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd,
  input  logic        ppu_send,
  input  logic        uad,
  input  logic        sac,
  input  logic [31:0] interface_data,
  output logic        eth_valid,
  input  logic        eth_ready,
  output logic [31:0] eth_data,
  output logic        ppu_valid,
  input  logic        ppu_ready,
  output logic [31:0] ppu_data,
  output logic        acc_valid,
  input  logic        acc_ready,
  output logic [31:0] acc_data,
  output logic        acc_op,
  output logic [2:0]  fifo_count,
  output logic        full,
  output logic        overflow,
  output logic        multi_err,
  input  logic        err_clr,
  output logic [7:0]  drop_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DROP_W = 8;

  typedef enum logic [1:0] {
    DST_ETH = 2'd0,
    DST_PPU = 2'd1,
    DST_UAD = 2'd2,
    DST_SAC = 2'd3
  } dst_e;

  typedef struct packed {
    dst_e              dst;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              multi_q, multi_d;

  entry_t            head;
  dst_e              push_dst;
  logic [CNT_W-1:0]  n_strobe;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              not_empty;
  logic              is_full;
  logic              head_ready;

  // Request decode: fixed priority snd > ppu_send > uad > sac
  always_comb begin
    push_dst = DST_SAC;
    n_strobe = CNT_W'(snd) + CNT_W'(ppu_send) + CNT_W'(uad) + CNT_W'(sac);
    push_req = snd | ppu_send | uad | sac;
    if (snd)           push_dst = DST_ETH;
    else if (ppu_send) push_dst = DST_PPU;
    else if (uad)      push_dst = DST_UAD;
  end

  // Head routing and pop/push qualification
  always_comb begin
    head       = mem_q[rd_ptr_q];
    not_empty  = (count_q != '0);
    is_full    = (count_q == CNT_W'(DEPTH));
    head_ready = 1'b0;
    case (head.dst)
      DST_ETH: head_ready = eth_ready;
      DST_PPU: head_ready = ppu_ready;
      default: head_ready = acc_ready;
    endcase
    pop     = not_empty & head_ready;
    push_ok = push_req & (~is_full | pop);
  end

  // Next-state for pointers, occupancy and sticky flags
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    multi_d    = multi_q;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
    if (push_req && !push_ok) overflow_d = 1'b1;
    if (n_strobe > CNT_W'(1)) multi_d = 1'b1;
    if (err_clr) begin
      overflow_d = 1'b0;
      multi_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      multi_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      multi_q    <= multi_d;
      if (push_ok) mem_q[wr_ptr_q] <= '{dst: push_dst, data: interface_data};
    end
  end

  // Only the head's destination port sees valid/data; the rest are zeroed
  always_comb begin
    eth_valid = not_empty && (head.dst == DST_ETH);
    ppu_valid = not_empty && (head.dst == DST_PPU);
    acc_valid = not_empty && ((head.dst == DST_UAD) || (head.dst == DST_SAC));
    eth_data  = eth_valid ? head.data : '0;
    ppu_data  = ppu_valid ? head.data : '0;
    acc_data  = acc_valid ? head.data : '0;
    acc_op    = acc_valid && (head.dst == DST_SAC);
  end

  assign fifo_count = count_q;
  assign full       = is_full;
  assign overflow   = overflow_q;
  assign multi_err  = multi_q;

`ifdef IO_DISPATCH_DROP_CNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0]  n_drop;
  logic [DROP_W:0]   drop_sum;

  // A rejected push loses every strobe; an accepted one loses only the losers
  always_comb begin
    n_drop   = push_ok ? (n_strobe - CNT_W'(1)) : n_strobe;
    drop_sum = (DROP_W+1)'(drop_q) + (DROP_W+1)'(n_drop);
    drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
    if (err_clr) drop_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) drop_q <= '0;
    else        drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_proc_io_dispatch.sv
// Directed scoreboard bench for proc_io_dispatch; expected head entries queued at push time.
module tb_proc_io_dispatch;

  localparam logic [1:0] K_ETH = 2'd0;
  localparam logic [1:0] K_PPU = 2'd1;
  localparam logic [1:0] K_UAD = 2'd2;
  localparam logic [1:0] K_SAC = 2'd3;

  typedef struct packed {
    logic [1:0]  dst;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd = 1'b0, ppu_send = 1'b0, uad = 1'b0, sac = 1'b0;
  logic [31:0] interface_data = '0;
  logic        eth_valid, ppu_valid, acc_valid, acc_op;
  logic        eth_ready = 1'b0, ppu_ready = 1'b0, acc_ready = 1'b0;
  logic [31:0] eth_data, ppu_data, acc_data;
  logic [2:0]  fifo_count;
  logic        full, overflow, multi_err;
  logic        err_clr = 1'b0;
  logic [7:0]  drop_count;

  int  checks   = 0;
  int  failures = 0;
  sb_t sb_q[$];

  proc_io_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .snd(snd), .ppu_send(ppu_send), .uad(uad), .sac(sac),
    .interface_data(interface_data),
    .eth_valid(eth_valid), .eth_ready(eth_ready), .eth_data(eth_data),
    .ppu_valid(ppu_valid), .ppu_ready(ppu_ready), .ppu_data(ppu_data),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .acc_op(acc_op),
    .fifo_count(fifo_count), .full(full), .overflow(overflow), .multi_err(multi_err),
    .err_clr(err_clr), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".eth_valid"}, 32'(eth_valid), 32'd0);
    chk({tag, ".ppu_valid"}, 32'(ppu_valid), 32'd0);
    chk({tag, ".acc_valid"}, 32'(acc_valid), 32'd0);
    chk({tag, ".eth_data"}, eth_data, 32'd0);
    chk({tag, ".ppu_data"}, ppu_data, 32'd0);
    chk({tag, ".acc_data"}, acc_data, 32'd0);
    chk({tag, ".acc_op"}, 32'(acc_op), 32'd0);
  endtask

  // Compare all three ports against the scoreboard front
  task automatic check_head(input string tag);
    sb_t e;
    logic is_eth, is_ppu, is_acc;
    if (sb_q.size() == 0) begin
      chk_idle(tag);
    end else begin
      e = sb_q[0];
      is_eth = (e.dst == K_ETH);
      is_ppu = (e.dst == K_PPU);
      is_acc = (e.dst == K_UAD) || (e.dst == K_SAC);
      chk({tag, ".eth_valid"}, 32'(eth_valid), 32'(is_eth));
      chk({tag, ".ppu_valid"}, 32'(ppu_valid), 32'(is_ppu));
      chk({tag, ".acc_valid"}, 32'(acc_valid), 32'(is_acc));
      chk({tag, ".eth_data"}, eth_data, is_eth ? e.data : 32'd0);
      chk({tag, ".ppu_data"}, ppu_data, is_ppu ? e.data : 32'd0);
      chk({tag, ".acc_data"}, acc_data, is_acc ? e.data : 32'd0);
      chk({tag, ".acc_op"}, 32'(acc_op), 32'(e.dst == K_SAC));
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] d, input bit stored);
    sb_t e;
    snd = (kind == K_ETH); ppu_send = (kind == K_PPU);
    uad = (kind == K_UAD); sac = (kind == K_SAC);
    interface_data = d;
    step();
    {snd, ppu_send, uad, sac} = 4'b0;
    interface_data = '0;
    if (stored) begin
      e.dst = kind; e.data = d;
      sb_q.push_back(e);
    end
  endtask

  // Raise ready only on the expected head's port for one cycle
  task automatic pop_head(input string tag);
    sb_t e;
    check_head(tag);
    e = sb_q[0];
    eth_ready = (e.dst == K_ETH);
    ppu_ready = (e.dst == K_PPU);
    acc_ready = (e.dst == K_UAD) || (e.dst == K_SAC);
    step();
    {eth_ready, ppu_ready, acc_ready} = 3'b0;
    void'(sb_q.pop_front());
  endtask

  task automatic drain(input string tag);
    int budget = 8;
    while (sb_q.size() != 0 && budget > 0) begin
      pop_head(tag);
      budget--;
    end
    chk({tag, ".drained_count"}, 32'(fifo_count), 32'd0);
    check_head({tag, ".after_drain"});
  endtask

  initial begin
    sb_t e;
    logic [7:0] exp_drop;

    // Reset state
    rst_n = 1'b0;
    step(); step();
    chk("rst.count", 32'(fifo_count), 32'd0);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    chk("rst.multi_err", 32'(multi_err), 32'd0);
    chk("rst.drop_count", 32'(drop_count), 32'd0);
    chk_idle("rst");
    rst_n = 1'b1;
    step();

    // Single ETH send, one-cycle latency, popped with ready already high
    eth_ready = 1'b1;
    push(K_ETH, 32'hDEADBEEF, 1'b1);
    check_head("eth1");
    chk("eth1.count", 32'(fifo_count), 32'd1);
    step();
    void'(sb_q.pop_front());
    eth_ready = 1'b0;
    chk("eth1.count_after", 32'(fifo_count), 32'd0);
    check_head("eth1.after");

    // Head-of-line blocking and stability under stall
    push(K_PPU, 32'h1, 1'b1);
    push(K_ETH, 32'h2, 1'b1);
    push(K_SAC, 32'h3, 1'b1);
    check_head("hol.stall");
    step(); step();
    check_head("hol.hold");
    chk("hol.count", 32'(fifo_count), 32'd3);
    eth_ready = 1'b1; acc_ready = 1'b1;
    step();
    eth_ready = 1'b0; acc_ready = 1'b0;
    chk("hol.wrong_ready_count", 32'(fifo_count), 32'd3);
    check_head("hol.wrong_ready");
    drain("hol");

    // Overflow on a full FIFO with nothing draining
    for (int i = 0; i < 4; i++) push(K_UAD, 32'h100 + 32'(i), 1'b1);
    chk("ovf.full4", 32'(full), 32'd1);
    chk("ovf.pre_flag", 32'(overflow), 32'd0);
    push(K_UAD, 32'h1FF, 1'b0);
    chk("ovf.count", 32'(fifo_count), 32'd4);
    chk("ovf.full", 32'(full), 32'd1);
    chk("ovf.flag", 32'(overflow), 32'd1);
`ifdef IO_DISPATCH_DROP_CNT_EN
    exp_drop = 8'd1;
`else
    exp_drop = 8'd0;
`endif
    chk("ovf.drop_count", 32'(drop_count), 32'(exp_drop));
    drain("ovf");
    chk("ovf.sticky", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf.clr", 32'(overflow), 32'd0);
    chk("ovf.clr_drop", 32'(drop_count), 32'd0);

    // Simultaneous strobes: priority winner stored, multi_err set
    snd = 1'b1; uad = 1'b1; interface_data = 32'h55;
    step();
    snd = 1'b0; uad = 1'b0; interface_data = '0;
    e.dst = K_ETH; e.data = 32'h55; sb_q.push_back(e);
    chk("multi.count", 32'(fifo_count), 32'd1);
    chk("multi.flag", 32'(multi_err), 32'd1);
    drain("multi");
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("multi.clr", 32'(multi_err), 32'd0);

    // err_clr wins over a same-cycle multi-strobe set
    ppu_send = 1'b1; sac = 1'b1; err_clr = 1'b1; interface_data = 32'h66;
    step();
    ppu_send = 1'b0; sac = 1'b0; err_clr = 1'b0; interface_data = '0;
    e.dst = K_PPU; e.data = 32'h66; sb_q.push_back(e);
    chk("clrprio.multi", 32'(multi_err), 32'd0);
    drain("clrprio");

    // Full FIFO: pop and push in the same cycle keeps count at 4
    push(K_SAC, 32'h10, 1'b1);
    push(K_UAD, 32'h11, 1'b1);
    push(K_SAC, 32'h12, 1'b1);
    push(K_UAD, 32'h13, 1'b1);
    acc_ready = 1'b1; sac = 1'b1; interface_data = 32'h99;
    step();
    acc_ready = 1'b0; sac = 1'b0; interface_data = '0;
    void'(sb_q.pop_front());
    e.dst = K_SAC; e.data = 32'h99; sb_q.push_back(e);
    chk("fullpp.count", 32'(fifo_count), 32'd4);
    chk("fullpp.overflow", 32'(overflow), 32'd0);
    drain("fullpp");

    // Reset mid-operation discards pending entries
    push(K_ETH, 32'hA1, 1'b1);
    push(K_PPU, 32'hA2, 1'b1);
    push(K_UAD, 32'hA3, 1'b1);
    chk("midrst.pre_count", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    step();
    sb_q.delete();
    chk("midrst.count", 32'(fifo_count), 32'd0);
    chk_idle("midrst");
    rst_n = 1'b1;
    step();
    chk("midrst.after_count", 32'(fifo_count), 32'd0);
    chk_idle("midrst.after");

    // Normal operation resumes after reset
    push(K_PPU, 32'hA5, 1'b1);
    drain("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
